// File: rtl/mem_req_if.sv
// Request/response bundle between a load/store queue and mem_req_buffer.
// Handshake: a request transfers on a posedge where valid_in=1 and stall_out=0 (no retry,
// stalled requests are dropped and flag overflow); ready_out is a one-cycle completion strobe.
interface mem_req_if;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic        rw_in;
    logic [3:0]  id_in;
    logic        valid_in;
    logic [31:0] data_out;
    logic [3:0]  id_out;
    logic        ready_out;
    logic        stall_out;
    logic        overflow;

    modport master (
        output addr_in, data_in, rw_in, id_in, valid_in,
        input  data_out, id_out, ready_out, stall_out, overflow
    );

    modport slave (
        input  addr_in, data_in, rw_in, id_in, valid_in,
        output data_out, id_out, ready_out, stall_out, overflow
    );
endinterface

// File: rtl/mem_req_buffer.sv
// In-order memory request buffer: a DEPTH-entry request FIFO feeding a fixed-latency
// service FSM in front of a 1024 x 32 word array.
module mem_req_buffer #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_req_if.slave                 bus,
    output logic [1:0]               dbg_state,
    output logic [$clog2(DEPTH):0]   dbg_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [31:0] mem [1024];

    logic [9:0]  fifo_idx  [DEPTH];
    logic [31:0] fifo_data [DEPTH];
    logic        fifo_rw   [DEPTH];
    logic [3:0]  fifo_id   [DEPTH];

    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [3:0]    cnt;

    logic [9:0]  svc_idx;
    logic [31:0] svc_data;
    logic        svc_rw;
    logic [3:0]  svc_id;

    logic stall, push, pop, access;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{bus.addr_in[31:12], bus.addr_in[1:0]};

    assign stall  = (count == CW'(DEPTH));
    assign push   = bus.valid_in && !stall;
    assign pop    = ((state == IDLE) || (state == RESP)) && (count != '0);
    assign access = (state == BUSY) && (cnt == 4'd0);

    assign bus.stall_out = stall;
    assign dbg_state     = state;
    assign dbg_count     = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[tail]  <= bus.addr_in[11:2];
            fifo_data[tail] <= bus.data_in;
            fifo_rw[tail]   <= bus.rw_in;
            fifo_id[tail]   <= bus.id_in;
        end
    end

    // The array is deliberately outside the reset domain so stored data survives rst.
    always_ff @(posedge clk) begin
        if (access && svc_rw) begin
            mem[svc_idx] <= svc_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            state         <= IDLE;
            cnt           <= 4'd0;
            svc_idx       <= 10'd0;
            svc_data      <= 32'd0;
            svc_rw        <= 1'b0;
            svc_id        <= 4'd0;
            bus.ready_out <= 1'b0;
            bus.data_out  <= 32'd0;
            bus.id_out    <= 4'd0;
            bus.overflow  <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.valid_in && stall) bus.overflow <= 1'b1;

            bus.ready_out <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (pop) begin
                        svc_idx  <= fifo_idx[head];
                        svc_data <= fifo_data[head];
                        svc_rw   <= fifo_rw[head];
                        svc_id   <= fifo_id[head];
                        // Loading LATENCY puts the access LATENCY+1 edges after the pop,
                        // so completions arrive every LATENCY+2 cycles.
                        cnt      <= 4'(LATENCY);
                        state    <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.ready_out <= 1'b1;
                        bus.id_out    <= svc_id;
                        bus.data_out  <= svc_rw ? svc_data : mem[svc_idx];
                        state         <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_buffer.sv
// Directed bench for mem_req_buffer (LATENCY=2, DEPTH=4); completions land 4 edges after push.
module tb_mem_req_buffer;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    logic [2:0] dbg_count;
    int         n_checks;
    int         n_fail;

    mem_req_if bus ();

    mem_req_buffer #(.LATENCY(2), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic rw, input logic [3:0] id);
        bus.valid_in = v;
        bus.addr_in  = a;
        bus.data_in  = d;
        bus.rw_in    = rw;
        bus.id_in    = id;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        step();
        step();
        n_checks++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready_out); end
        n_checks++; if (bus.data_out !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.data_out); end
        n_checks++; if (bus.id_out !== 4'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", bus.id_out); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        n_checks++; if (bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_out); end
        n_checks++; if (dbg_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", dbg_count); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst = 1'b1;
    endtask

    task automatic test_store();
        logic exp_r;
        drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 4'd3);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        n_checks++; if (dbg_count !== 3'd1) begin n_fail++; $display("FAIL store_accept: count %0d want 1", dbg_count); end
        for (int t = 1; t <= 7; t++) begin
            step();
            exp_r = (t == 4);
            n_checks++; if (bus.ready_out !== exp_r) begin n_fail++; $display("FAIL store_ready t=%0d: got %b want %b", t, bus.ready_out, exp_r); end
            if (t == 4 || t == 7) begin
                n_checks++; if (bus.id_out !== 4'd3) begin n_fail++; $display("FAIL store_id t=%0d: got %0d want 3", t, bus.id_out); end
                n_checks++; if (bus.data_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_data t=%0d: got %h want deadbeef", t, bus.data_out); end
            end
        end
    endtask

    task automatic test_load();
        logic [31:0] addrs [2];
        logic [3:0]  ids   [2];
        logic        exp_r;
        addrs[0] = 32'h10;   ids[0] = 4'd5;
        addrs[1] = 32'h1010; ids[1] = 4'd6;
        for (int v = 0; v < 2; v++) begin
            drive(1'b1, addrs[v], 32'h0, 1'b0, ids[v]);
            step();
            drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
            for (int t = 1; t <= 5; t++) begin
                step();
                exp_r = (t == 4);
                n_checks++; if (bus.ready_out !== exp_r) begin n_fail++; $display("FAIL load%0d_ready t=%0d: got %b want %b", v, t, bus.ready_out, exp_r); end
                if (t == 4) begin
                    n_checks++; if (bus.id_out !== ids[v]) begin n_fail++; $display("FAIL load%0d_id: got %0d want %0d", v, bus.id_out, ids[v]); end
                    n_checks++; if (bus.data_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load%0d_data: got %h want deadbeef", v, bus.data_out); end
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [3:0]  exp_id_q [$];
        logic [31:0] exp_q [$];
        logic [3:0]  eid;
        logic [31:0] ed;
        logic        exp_r;
        exp_id_q = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        exp_q    = {32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        for (int t = 0; t <= 23; t++) begin
            if (t < 6) drive(1'b1, 32'h100 + 32'(4 * t), 32'hA0 + 32'(t), 1'b1, 4'(t + 1));
            else       drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
            step();
            if (t == 3) begin
                n_checks++; if (bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL ovf_stall_t3: got %b want 0", bus.stall_out); end
                n_checks++; if (dbg_count !== 3'd3) begin n_fail++; $display("FAIL ovf_count_t3: got %0d want 3", dbg_count); end
            end
            if (t == 4) begin
                n_checks++; if (bus.stall_out !== 1'b1) begin n_fail++; $display("FAIL ovf_stall_t4: got %b want 1", bus.stall_out); end
                n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_flag_t4: got %b want 0", bus.overflow); end
            end
            if (t == 5) begin
                n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag_t5: got %b want 1", bus.overflow); end
                n_checks++; if (dbg_count !== 3'd3) begin n_fail++; $display("FAIL ovf_count_t5: got %0d want 3", dbg_count); end
            end
            exp_r = (t >= 4) && (t <= 20) && (t % 4 == 0);
            n_checks++; if (bus.ready_out !== exp_r) begin n_fail++; $display("FAIL ovf_ready t=%0d: got %b want %b", t, bus.ready_out, exp_r); end
            if (bus.ready_out === 1'b1 && exp_id_q.size() > 0) begin
                eid = exp_id_q.pop_front();
                ed  = exp_q.pop_front();
                n_checks++; if (bus.id_out !== eid) begin n_fail++; $display("FAIL ovf_id t=%0d: got %0d want %0d", t, bus.id_out, eid); end
                n_checks++; if (bus.data_out !== ed) begin n_fail++; $display("FAIL ovf_data t=%0d: got %h want %h", t, bus.data_out, ed); end
            end
        end
        n_checks++; if (exp_id_q.size() != 0) begin n_fail++; $display("FAIL ovf_missing: got %0d left want 0", exp_id_q.size()); end
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
        n_checks++; if (dbg_count !== 3'd0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL ovf_drain: count %0d state %0d want 0 0", dbg_count, dbg_state); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_id_q [$];
        logic [31:0] exp_q [$];
        logic [3:0]  eid;
        logic [31:0] ed;
        logic        exp_r;
        exp_id_q = {4'd7, 4'd8, 4'd9, 4'd10};
        exp_q    = {32'hA0, 32'h55, 32'h55, 32'hA3};
        for (int t = 0; t <= 18; t++) begin
            case (t)
                0:       drive(1'b1, 32'h100, 32'h0,  1'b0, 4'd7);
                1:       drive(1'b1, 32'h200, 32'h55, 1'b1, 4'd8);
                2:       drive(1'b1, 32'h200, 32'h0,  1'b0, 4'd9);
                5:       drive(1'b1, 32'h10C, 32'h0,  1'b0, 4'd10);
                default: drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
            endcase
            step();
            if (t == 4 || t == 5) begin
                n_checks++; if (dbg_count !== 3'd2) begin n_fail++; $display("FAIL b2b_count t=%0d: got %0d want 2", t, dbg_count); end
            end
            exp_r = (t >= 4) && (t <= 16) && (t % 4 == 0);
            n_checks++; if (bus.ready_out !== exp_r) begin n_fail++; $display("FAIL b2b_ready t=%0d: got %b want %b", t, bus.ready_out, exp_r); end
            if (bus.ready_out === 1'b1 && exp_id_q.size() > 0) begin
                eid = exp_id_q.pop_front();
                ed  = exp_q.pop_front();
                n_checks++; if (bus.id_out !== eid) begin n_fail++; $display("FAIL b2b_id t=%0d: got %0d want %0d", t, bus.id_out, eid); end
                n_checks++; if (bus.data_out !== ed) begin n_fail++; $display("FAIL b2b_data t=%0d: got %h want %h", t, bus.data_out, ed); end
            end
        end
        n_checks++; if (exp_id_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing: got %0d left want 0", exp_id_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic exp_r;
        for (int t = 0; t <= 4; t++) begin
            case (t)
                0:       drive(1'b1, 32'h300, 32'h1234, 1'b1, 4'd1);
                1:       drive(1'b1, 32'h300, 32'h0,    1'b0, 4'd2);
                2:       drive(1'b1, 32'h10,  32'h0,    1'b0, 4'd3);
                default: drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
            endcase
            step();
        end
        n_checks++; if (bus.ready_out !== 1'b1 || bus.data_out !== 32'h1234) begin n_fail++; $display("FAIL rmid_access: ready %b data %h want 1 1234", bus.ready_out, bus.data_out); end
        n_checks++; if (dbg_count !== 3'd2) begin n_fail++; $display("FAIL rmid_queued: got %0d want 2", dbg_count); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got %b want 0", bus.ready_out); end
        n_checks++; if (bus.data_out !== 32'd0) begin n_fail++; $display("FAIL rmid_data: got %h want 0", bus.data_out); end
        n_checks++; if (bus.id_out !== 4'd0) begin n_fail++; $display("FAIL rmid_id: got %0d want 0", bus.id_out); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_overflow: got %b want 0", bus.overflow); end
        n_checks++; if (dbg_count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", dbg_count); end
        step();
        step();
        rst = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            n_checks++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL rmid_ghost t=%0d: got %b want 0", t, bus.ready_out); end
        end
        drive(1'b1, 32'h300, 32'h0, 1'b0, 4'd4);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        for (int t = 1; t <= 5; t++) begin
            step();
            exp_r = (t == 4);
            n_checks++; if (bus.ready_out !== exp_r) begin n_fail++; $display("FAIL rmid_load_ready t=%0d: got %b want %b", t, bus.ready_out, exp_r); end
            if (t == 4) begin
                n_checks++; if (bus.data_out !== 32'h1234) begin n_fail++; $display("FAIL rmid_retained: got %h want 1234", bus.data_out); end
                n_checks++; if (bus.id_out !== 4'd4) begin n_fail++; $display("FAIL rmid_load_id: got %0d want 4", bus.id_out); end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_store();
        test_load();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
